// File: rtl/midi_rx_ctrl.sv
// midi_rx_ctrl: MIDI byte-stream parser between a UART receiver and MIDI event logic
//
// Drives the receiver's baud divider, consumes bytes through the rdy/clr_rdy
// handshake, assembles channel messages (with running status) and realtime
// messages, and holds each one in a single-entry valid/ready output register.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   uart_rdy        receiver has a byte pending on uart_data
//   uart_data       received byte
//   uart_clr_rdy    one-cycle consume strobe back to the receiver
//   uart_clk_div    constant baud divider (bit period = CLK_DIV+1 clocks)
//   msg_valid       output message present
//   msg_ready       downstream accepts the message
//   msg_status      status byte of the message
//   msg_data1/2     data bytes, zero when unused
//   msg_len         number of data bytes (0, 1 or 2)
//   overrun         sticky: the receiver lost a byte
//   drop_cnt        saturating count of data bytes with no running status
module midi_rx_ctrl #(
    parameter logic [15:0] CLK_DIV = 16'd1599
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rdy,
    input  logic [7:0]  uart_data,
    output logic        uart_clr_rdy,
    output logic [15:0] uart_clk_div,
    output logic        msg_valid,
    input  logic        msg_ready,
    output logic [7:0]  msg_status,
    output logic [7:0]  msg_data1,
    output logic [7:0]  msg_data2,
    output logic [1:0]  msg_len,
    output logic        overrun,
    output logic [7:0]  drop_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT_D1, S_WAIT_D2, S_SYSEX} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_rs;
    logic [7:0]  r_d1;
    logic        r_valid;
    logic [7:0]  r_status;
    logic [7:0]  r_data1;
    logic [7:0]  r_data2;
    logic [1:0]  r_len;
    logic        r_overrun;
    logic [7:0]  r_drop;
    logic        r_rdy_q;
    logic        r_clr_q;

    logic        w_is_data;
    logic        w_is_rt;
    logic        w_is_chan;
    logic        w_is_f0;
    logic        w_is_sc;
    logic        w_one;
    logic        w_complete;
    logic        w_take;
    logic [7:0]  w_status;
    logic [7:0]  w_d1;
    logic [7:0]  w_d2;
    logic [1:0]  w_len;

    assign w_is_data = ~uart_data[7];
    assign w_is_rt   = &uart_data[7:3];
    assign w_is_chan = uart_data[7] & ~&uart_data[6:4];
    assign w_is_f0   = uart_data == 8'hF0;
    assign w_is_sc   = (uart_data[7:3] == 5'b11110) & ~w_is_f0;
    // Program change and channel pressure (0xC0-0xDF) carry one data byte.
    assign w_one     = r_rs[7:5] == 3'b110;

    // A byte that would complete a message is held off while the output
    // register is occupied and not being drained this cycle.
    assign w_take       = uart_rdy & ~(w_complete & r_valid & ~msg_ready);
    assign uart_clr_rdy = w_take;
    assign uart_clk_div = CLK_DIV;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_take)
            w_next = w_is_chan ? S_WAIT_D1 :
                     w_is_f0   ? S_SYSEX :
                     w_is_sc   ? S_IDLE :
                     (w_is_data & r_state == S_WAIT_D1 & ~w_one) ? S_WAIT_D2 :
                     (w_is_data & r_state == S_WAIT_D2) ? S_WAIT_D1 : r_state;
    end

    always_comb begin
        w_complete = w_is_rt | (w_is_data & ((r_state == S_WAIT_D1 & w_one) | r_state == S_WAIT_D2));
        w_status   = w_is_rt ? uart_data : r_rs;
        w_len      = w_is_rt ? 2'd0 : (r_state == S_WAIT_D2 ? 2'd2 : 2'd1);
        w_d1       = w_is_rt ? 8'h00 : (r_state == S_WAIT_D2 ? r_d1 : uart_data);
        w_d2       = (~w_is_rt & r_state == S_WAIT_D2) ? uart_data : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rs      <= 8'h00;
            r_d1      <= 8'h00;
            r_valid   <= 1'b0;
            r_status  <= 8'h00;
            r_data1   <= 8'h00;
            r_data2   <= 8'h00;
            r_len     <= 2'd0;
            r_overrun <= 1'b0;
            r_drop    <= 8'h00;
            r_rdy_q   <= 1'b0;
            r_clr_q   <= 1'b0;
        end else begin
            r_rdy_q <= uart_rdy;
            r_clr_q <= w_take;
            // rdy falling without having been consumed: the receiver started a new byte.
            if (r_rdy_q & ~r_clr_q & ~uart_rdy) r_overrun <= 1'b1;
            if (w_take & w_is_chan) begin
                r_rs <= uart_data;
                r_d1 <= 8'h00;
            end else if (w_take & (w_is_f0 | w_is_sc)) begin
                r_rs <= 8'h00;
            end else if (w_take & w_is_data & r_state == S_WAIT_D1 & ~w_one) begin
                r_d1 <= uart_data;
            end
            if (w_take & w_is_data & r_state == S_IDLE & ~&r_drop) r_drop <= r_drop + 8'd1;
            if (w_take & w_complete) begin
                r_valid  <= 1'b1;
                r_status <= w_status;
                r_data1  <= w_d1;
                r_data2  <= w_d2;
                r_len    <= w_len;
            end else if (msg_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign msg_valid  = r_valid;
    assign msg_status = r_status;
    assign msg_data1  = r_data1;
    assign msg_data2  = r_data2;
    assign msg_len    = r_len;
    assign overrun    = r_overrun;
    assign drop_cnt   = r_drop;
endmodule

// File: tb/tb_midi_rx_ctrl.sv
// tb_midi_rx_ctrl: directed vectors, hand-written corner sequences and a randomized model check for midi_rx_ctrl
module tb_midi_rx_ctrl;
    typedef struct packed {
        logic [7:0] s;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [1:0] len;
    } msg_t;

    typedef struct {
        string           name;
        logic [0:5][7:0] b;
        int              n;
        int              cnt;
        msg_t            first;
        msg_t            last;
        int              drop;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rdy = 1'b0;
    logic [7:0]  uart_data = 8'h00;
    logic        uart_clr_rdy;
    logic [15:0] uart_clk_div;
    logic        msg_valid;
    logic        msg_ready = 1'b1;
    logic [7:0]  msg_status;
    logic [7:0]  msg_data1;
    logic [7:0]  msg_data2;
    logic [1:0]  msg_len;
    logic        overrun;
    logic [7:0]  drop_cnt;

    int   errors = 0;
    int   checks = 0;
    bit   rnd_rdy = 0;
    msg_t mq[$];
    int   clr_cnt = 0;
    int   vcyc = 0;

    int         m_rs;
    bit         m_sysex;
    logic [7:0] m_buf[$];
    int         m_drop;
    msg_t       eq[$];

    vec_t vecs[8];

    midi_rx_ctrl dut (
        .clk(clk), .rst(rst), .uart_rdy(uart_rdy), .uart_data(uart_data),
        .uart_clr_rdy(uart_clr_rdy), .uart_clk_div(uart_clk_div),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_status(msg_status),
        .msg_data1(msg_data1), .msg_data2(msg_data2), .msg_len(msg_len),
        .overrun(overrun), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (msg_valid && msg_ready) mq.push_back({msg_status, msg_data1, msg_data2, msg_len});
        if (uart_clr_rdy) clr_cnt++;
        if (msg_valid) vcyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        uart_rdy = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        uart_data = b;
        uart_rdy = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = uart_clr_rdy;
            @(posedge clk); #1;
            if (rnd_rdy) msg_ready = 1'($urandom_range(0, 1));
        end
        uart_rdy = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout byte=%0h actual=not_consumed required=consumed", b);
        end
        @(posedge clk); #1;
        if (rnd_rdy) msg_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic model_reset();
        m_rs = -1;
        m_sysex = 0;
        m_buf.delete();
        m_drop = 0;
        eq.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [1:0] need;
        if (b >= 8'hF8) begin
            eq.push_back({b, 8'h00, 8'h00, 2'd0});
        end else if (b == 8'hF0) begin
            m_rs = -1; m_sysex = 1; m_buf.delete();
        end else if (b > 8'hF0) begin
            m_rs = -1; m_sysex = 0; m_buf.delete();
        end else if (b >= 8'h80) begin
            m_rs = int'(b); m_sysex = 0; m_buf.delete();
        end else if (m_rs >= 0) begin
            m_buf.push_back(b);
            need = (m_rs >= 'hC0 && m_rs < 'hE0) ? 2'd1 : 2'd2;
            if (m_buf.size() == int'(need)) begin
                eq.push_back({m_rs[7:0], m_buf[0], (need == 2'd2) ? m_buf[1] : 8'h00, need});
                m_buf.delete();
            end
        end else if (!m_sysex && m_drop < 255) begin
            m_drop++;
        end
    endtask

    function automatic logic [7:0] rand_byte();
        int r = int'($urandom_range(0, 99));
        if (r < 60) return 8'($urandom_range(0, 8'h7F));
        if (r < 85) return 8'($urandom_range(8'h80, 8'hEF));
        if (r < 92) return 8'($urandom_range(8'hF8, 8'hFF));
        if (r < 97) return 8'($urandom_range(8'hF1, 8'hF7));
        return 8'hF0;
    endfunction

    initial begin
        int base, cbase, vbase, got;
        vecs[0] = '{"note_on",     {8'h90, 8'h3C, 8'h64, 24'h0}, 3, 1, {8'h90, 8'h3C, 8'h64, 2'd2}, {8'h90, 8'h3C, 8'h64, 2'd2}, 0};
        vecs[1] = '{"running",     {8'h90, 8'h3C, 8'h64, 8'h3E, 8'h00, 8'h0}, 5, 2, {8'h90, 8'h3C, 8'h64, 2'd2}, {8'h90, 8'h3E, 8'h00, 2'd2}, 0};
        vecs[2] = '{"rt_interlv",  {8'h90, 8'h3C, 8'hF8, 8'h64, 16'h0}, 4, 2, {8'hF8, 8'h00, 8'h00, 2'd0}, {8'h90, 8'h3C, 8'h64, 2'd2}, 0};
        vecs[3] = '{"prog_chg",    {8'hC5, 8'h07, 32'h0}, 2, 1, {8'hC5, 8'h07, 8'h00, 2'd1}, {8'hC5, 8'h07, 8'h00, 2'd1}, 0};
        vecs[4] = '{"sysex",       {8'hF0, 8'h01, 8'h02, 8'hF7, 8'h40, 8'h0}, 5, 0, 26'h0, 26'h0, 1};
        vecs[5] = '{"prog_run",    {8'hC5, 8'h07, 8'h09, 24'h0}, 3, 2, {8'hC5, 8'h07, 8'h00, 2'd1}, {8'hC5, 8'h09, 8'h00, 2'd1}, 0};
        vecs[6] = '{"idle_drop",   {8'h3C, 8'h3C, 8'h3C, 24'h0}, 3, 0, 26'h0, 26'h0, 3};
        vecs[7] = '{"rt_in_sysex", {8'hF0, 8'h01, 8'hFA, 8'h02, 8'hF7, 8'h0}, 5, 1, {8'hFA, 8'h00, 8'h00, 2'd0}, {8'hFA, 8'h00, 8'h00, 2'd0}, 0};

        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        chk("rst_valid", msg_valid, 0);
        chk("rst_fields", {msg_status, msg_data1, msg_data2, msg_len}, 0);
        chk("rst_overrun_drop", {overrun, drop_cnt}, 0);
        chk("clk_div", uart_clk_div, 16'd1599);
        @(posedge clk); #1;

        foreach (vecs[k]) begin
            do_reset();
            msg_ready = 1'b1;
            base = mq.size(); cbase = clr_cnt; vbase = vcyc;
            for (int i = 0; i < vecs[k].n; i++) send_byte(vecs[k].b[i]);
            repeat (3) @(posedge clk);
            @(negedge clk);
            got = mq.size() - base;
            chk({vecs[k].name, "_count"}, got, vecs[k].cnt);
            chk({vecs[k].name, "_clr"}, clr_cnt - cbase, vecs[k].n);
            chk({vecs[k].name, "_vcyc"}, vcyc - vbase, vecs[k].cnt);
            chk({vecs[k].name, "_drop"}, drop_cnt, vecs[k].drop);
            if (got > 0 && got == vecs[k].cnt) begin
                chk({vecs[k].name, "_first"}, mq[base], vecs[k].first);
                chk({vecs[k].name, "_last"}, mq[mq.size() - 1], vecs[k].last);
            end
            @(posedge clk); #1;
        end

        // backpressure then overrun
        do_reset();
        msg_ready = 1'b0;
        base = mq.size();
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        send_byte(8'h90); send_byte(8'h3C);
        uart_data = 8'h64;
        uart_rdy = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_withheld", uart_clr_rdy, 0);
        end
        chk("bp_held_valid", msg_valid, 1);
        chk("bp_held_msg", {msg_status, msg_data1, msg_data2, msg_len}, {8'h90, 8'h3C, 8'h64, 2'd2});
        @(posedge clk); #1;
        uart_rdy = 1'b0;
        @(negedge clk);
        chk("bp_no_overrun_yet", overrun, 0);
        @(posedge clk);
        @(negedge clk);
        chk("bp_overrun", overrun, 1);
        @(posedge clk); #1;
        msg_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_transfer", mq.size() - base, 1);
        chk("bp_valid_fell", msg_valid, 0);
        chk("bp_overrun_sticky", overrun, 1);
        @(posedge clk); #1;

        // withheld realtime byte accepted when ready rises, loads back-to-back
        do_reset();
        msg_ready = 1'b0;
        base = mq.size();
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        uart_data = 8'hF8;
        uart_rdy = 1'b1;
        @(negedge clk);
        chk("b2b_withheld", uart_clr_rdy, 0);
        @(posedge clk); #1;
        msg_ready = 1'b1;
        @(negedge clk);
        chk("b2b_accept", uart_clr_rdy, 1);
        @(posedge clk); #1;
        uart_rdy = 1'b0;
        msg_ready = 1'b0;
        @(negedge clk);
        chk("b2b_valid", msg_valid, 1);
        chk("b2b_msg", {msg_status, msg_data1, msg_data2, msg_len}, {8'hF8, 8'h00, 8'h00, 2'd0});
        chk("b2b_first_out", mq.size() - base, 1);
        chk("b2b_no_overrun", overrun, 0);
        @(posedge clk); #1;
        msg_ready = 1'b1;

        // reset mid-message with a held output
        do_reset();
        msg_ready = 1'b0;
        base = mq.size();
        send_byte(8'hC5); send_byte(8'h07);
        send_byte(8'h90); send_byte(8'h3C);
        chk("midrst_held", msg_valid, 1);
        do_reset();
        @(negedge clk);
        chk("midrst_valid", msg_valid, 0);
        chk("midrst_fields", {msg_status, msg_data1, msg_data2, msg_len, overrun, drop_cnt}, 0);
        @(posedge clk); #1;
        msg_ready = 1'b1;
        send_byte(8'h64);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst_drop", drop_cnt, 1);
        chk("midrst_nomsg", mq.size() - base, 0);
        @(posedge clk); #1;

        // drop counter saturation
        do_reset();
        for (int i = 0; i < 260; i++) send_byte(8'h11);
        @(negedge clk);
        chk("drop_sat", drop_cnt, 8'd255);
        @(posedge clk); #1;

        // randomized stream with random backpressure against the model
        do_reset();
        model_reset();
        base = mq.size();
        rnd_rdy = 1;
        for (int i = 0; i < 500; i++) begin
            logic [7:0] b = rand_byte();
            model_byte(b);
            send_byte(b);
        end
        rnd_rdy = 0;
        msg_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        got = mq.size() - base;
        chk("rnd_count", got, eq.size());
        for (int i = 0; i < got && i < eq.size(); i++) chk("rnd_msg", mq[base + i], eq[i]);
        chk("rnd_drop", drop_cnt, m_drop[7:0]);
        chk("rnd_overrun", overrun, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/midi_rx_ctrl.md
Name: midi_rx_ctrl

Overview:
- Controller that sits between the UART receiver and the MIDI event logic.
- Drives the receiver's baud divider and consumes received bytes through the rdy/clr_rdy handshake.
- Parses the byte stream into complete MIDI channel and realtime messages, supporting running status.
- Presents each message on a single-entry valid/ready output register and flags receiver overrun.

Parameters:
- CLK_DIV, 16'd1599: constant driven onto uart_clk_div. The receiver bit period is CLK_DIV+1 clocks, so 1599 gives 31.25 kbaud at 50 MHz.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- uart_rdy  input  1  receiver byte-ready flag
- uart_data  input  8  receiver byte, valid while uart_rdy=1
- uart_clr_rdy  output  1  combinational one-cycle consume strobe to receiver
- uart_clk_div  output  16  constant CLK_DIV
- msg_valid  output  1  output message present
- msg_ready  input  1  downstream accepts message
- msg_status  output  8  status byte of message
- msg_data1  output  8  first data byte, 0 if unused
- msg_data2  output  8  second data byte, 0 if unused
- msg_len  output  2  number of data bytes: 0, 1 or 2
- overrun  output  1  sticky; a receiver byte was lost
- drop_cnt  output  8  saturating count of orphan data bytes

Behaviour:
- Reset, synchronous on clk: msg_valid=0, msg_status/data1/data2=0, msg_len=0, overrun=0, drop_cnt=0, running status cleared, parser=IDLE. Reset mid-message discards the partial message and any held output.
- Byte classes:
  - data: bit7=0.
  - 2-data status: 0x80-0xBF and 0xE0-0xEF.
  - 1-data status: 0xC0-0xDF.
  - system common: 0xF0-0xF7.
  - realtime: 0xF8-0xFF.
- Parser states: IDLE (no running status), WAIT_D1, WAIT_D2, SYSEX.
- Channel status byte, any state: store as running status, clear data registers, go to WAIT_D1.
- WAIT_D1 + data byte:
  - 1-data status: message complete (len 1), stay in WAIT_D1.
  - 2-data status: latch data1, go to WAIT_D2.
- WAIT_D2 + data byte: message complete (len 2), return to WAIT_D1. Running status is retained.
- IDLE + data byte: byte dropped; drop_cnt increments and saturates at 255.
- 0xF0: clear running status, go to SYSEX. Data bytes in SYSEX are discarded without counting.
- 0xF1-0xF7, any state: clear running status, go to IDLE.
- Realtime byte, any state: emit a len-0 message immediately. Parser state, running status and partial data are untouched.
- Consume rule, combinational: uart_clr_rdy = uart_rdy & accept.
  - accept=1 unless the byte would complete a message (including realtime) while msg_valid=1 and msg_ready=0.
  - A withheld byte stays pending on uart_rdy; it is re-evaluated each cycle and accepted the first cycle the condition clears.
  - The byte is processed in the same cycle uart_clr_rdy=1.
- Output register:
  - Loads on completion; msg_valid rises the next cycle.
  - Transfer occurs on a cycle with msg_valid & msg_ready. msg_valid falls, unless a new message completes that same cycle, in which case it loads back-to-back.
  - Fields are stable while msg_valid=1 and msg_ready=0.
- Latency: msg_valid rises 1 cycle after the final byte is consumed.
- Overrun: register uart_rdy and uart_clr_rdy by one cycle. If the previous uart_rdy=1, the previous uart_clr_rdy=0, and the current uart_rdy=0, set overrun. This is the receiver dropping rdy on a new start bit. overrun clears only on rst.
- uart_clk_div = CLK_DIV at all times, including reset.

Test Plan:
- Basic note on: rx 0x90,0x3C,0x64 with msg_ready=1 -> uart_clr_rdy pulses 3 times (one per byte), one message 0x90/0x3C/0x64, len 2, msg_valid high 1 cycle.
- Running status: 0x90,0x3C,0x64,0x3E,0x00 -> two messages; second is 0x90/0x3E/0x00, len 2.
- Realtime interleave: 0x90,0x3C,0xF8,0x64 -> 0xF8 len 0 emitted first, then 0x90/0x3C/0x64 len 2.
- Program change and sysex: 0xC5,0x07 -> 0xC5/0x07/0x00 len 1. Then 0xF0,0x01,0x02,0xF7,0x40 -> no messages, drop_cnt=1.
- Backpressure and overrun:
  - msg_ready=0, send two note ons -> the second note on's last byte is not consumed and uart_clr_rdy stays 0.
  - The next start bit (uart_rdy falls) -> overrun=1.
  - Raise msg_ready -> first message transfers; overrun stays 1.
- Reset mid-message: 0x90,0x3C, then rst for 1 cycle, then 0x64 -> no message, drop_cnt=1, all outputs at reset values after rst.
